alu_operand_select: RTL and testbench
=====================================

Name: alu_operand_select

Overview:
- Registered operand-select stage in front of the ALU of the single-issue MIPS-style CPU.
- Chooses ALU operand X from four sources and operand Y from eight sources: register values, PC, immediate fields extracted from the instruction, and constants.
- Registers the results with a valid flag, so the ALU sees stable operands one cycle after the request.

Parameters:
- DATA_W, 32, datapath width; instruction field positions assume 32.
- PC_INC, 4, constant returned by aluY=4 (return-address computation).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  capture enable; 0 = hold all outputs
- in_valid  in  1  request qualifier, captured with operands
- pc  in  DATA_W  current program counter
- regTValue  in  DATA_W  rt register value
- regSValue  in  DATA_W  rs register value
- instruction  in  32  current instruction word
- aluX  in  2  X operand select
- aluY  in  3  Y operand select
- resultX  out  DATA_W  registered X operand
- resultY  out  DATA_W  registered Y operand
- out_valid  out  1  registered in_valid

Behaviour:
- Reset (rst_n=0, asynchronous): resultX=0, resultY=0, out_valid=0 immediately. This holds while rst_n is low regardless of clk or en.
- Reset release: the first capture happens on the first rising clk edge with rst_n=1 and en=1.
- Latency: 1 cycle. At a rising edge with en=1, resultX/resultY/out_valid load the selections computed from the current inputs.
- Hold: with en=0, all three outputs keep their values.
- Capture ignores in_valid. Operands are loaded whenever en=1, and out_valid simply mirrors the captured in_valid.
- X select:
  - 0 = regSValue
  - 1 = regTValue
  - 2 = pc
  - 3 = 0
- Y select:
  - 0 = regTValue
  - 1 = sign-extend(instruction[15:0])
  - 2 = zero-extend(instruction[15:0])
  - 3 = zero-extend(instruction[10:6]) (shamt)
  - 4 = PC_INC
  - 5 = {instruction[15:0], 16'h0} (lui)
  - 6 = sign-extend(instruction[15:0]) << 2 (branch offset)
  - 7 = 0
- Combinational select is a full case with no latches. Every encoding maps to a defined value.
- Inputs are sampled only at the clock edge; changes between edges have no effect on the outputs until the next enabled edge.
- No arithmetic is performed; the shift for Y=6 is a wiring shift with upper bits discarded.

Decomposition:
- Shared package cpu_pkg:
  - X select constants: ALUX_RS=0, ALUX_RT=1, ALUX_PC=2, ALUX_ZERO=3.
  - Y select constants: ALUY_RT=0, ALUY_SIMM=1, ALUY_ZIMM=2, ALUY_SHAMT=3, ALUY_PC4=4, ALUY_LUI=5, ALUY_BOFF=6, ALUY_ZERO=7.
  - Select widths 2 and 3.
- One sub-module, imm_extend:
  - Input: the instruction word.
  - Outputs: simm, zimm, shamt, lui and boff values, all purely combinational.
- Top level holds the two selection muxes and the output register.

Test Plan:
All scenarios use pc=104, regTValue=0x1234, regSValue=0x5678, instruction=0x0000ABCD, en=1, in_valid=1.
- Reset: assert rst_n=0 mid-cycle -> resultX=0, resultY=0, out_valid=0 immediately, without waiting for a clock edge. Release rst_n -> outputs stay 0 until the next enabled edge.
- X sweep with aluY=0, one edge each:
  - aluX 0 -> 0x5678
  - aluX 1 -> 0x1234
  - aluX 2 -> 104 (0x68)
  - aluX 3 -> 0
  - resultY=0x1234 throughout
- Y sweep with aluX=3, one edge each:
  - aluY 1 -> 0xFFFFABCD
  - aluY 2 -> 0x0000ABCD
  - aluY 3 -> 0x0000000F
  - aluY 4 -> 0x00000004
  - aluY 5 -> 0xABCD0000
  - aluY 6 -> 0xFFFEAF34
  - aluY 7 -> 0
- Latency: change aluX 1->2 just after an edge -> resultX stays 0x1234 until the next rising edge, then becomes 0x68. out_valid tracks in_valid toggles with the same 1-cycle delay.
- Hold: en=0, then change aluX, aluY and all data inputs -> outputs unchanged over 3 edges. Set en=1 -> new values appear on the next edge.
- Positive immediate: instruction=0x00001234, aluY=1 -> 0x00001234; aluY=6 -> 0x000048D0; aluY=3 -> 0x00000008.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU operand select encodings and their widths.
package cpu_pkg;

  localparam int ALUX_W = 2;
  localparam int ALUY_W = 3;

  localparam logic [ALUX_W-1:0] ALUX_RS   = 2'd0;
  localparam logic [ALUX_W-1:0] ALUX_RT   = 2'd1;
  localparam logic [ALUX_W-1:0] ALUX_PC   = 2'd2;
  localparam logic [ALUX_W-1:0] ALUX_ZERO = 2'd3;

  localparam logic [ALUY_W-1:0] ALUY_RT    = 3'd0;
  localparam logic [ALUY_W-1:0] ALUY_SIMM  = 3'd1;
  localparam logic [ALUY_W-1:0] ALUY_ZIMM  = 3'd2;
  localparam logic [ALUY_W-1:0] ALUY_SHAMT = 3'd3;
  localparam logic [ALUY_W-1:0] ALUY_PC4   = 3'd4;
  localparam logic [ALUY_W-1:0] ALUY_LUI   = 3'd5;
  localparam logic [ALUY_W-1:0] ALUY_BOFF  = 3'd6;
  localparam logic [ALUY_W-1:0] ALUY_ZERO  = 3'd7;

endpackage

// File: rtl/imm_extend.sv
// Immediate-field extraction from the instruction word; pure wiring, no arithmetic.
module imm_extend #(
  parameter int DATA_W = 32
) (
  input  logic [31:0]       instruction,
  output logic [DATA_W-1:0] simm,
  output logic [DATA_W-1:0] zimm,
  output logic [DATA_W-1:0] shamt,
  output logic [DATA_W-1:0] lui,
  output logic [DATA_W-1:0] boff
);

  assign simm  = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};
  assign zimm  = {{(DATA_W-16){1'b0}}, instruction[15:0]};
  assign shamt = {{(DATA_W-5){1'b0}}, instruction[10:6]};
  assign lui   = {instruction[15:0], {(DATA_W-16){1'b0}}};
  // Branch offset: word-aligned shift of the sign-extended immediate, top bits dropped.
  assign boff  = {simm[DATA_W-3:0], 2'b00};

endmodule

// File: rtl/alu_operand_select.sv
// Registered ALU operand-select stage: picks X and Y operands and captures them with a valid flag.
module alu_operand_select
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_INC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] regTValue,
  input  logic [DATA_W-1:0] regSValue,
  input  logic [31:0]       instruction,
  input  logic [ALUX_W-1:0] aluX,
  input  logic [ALUY_W-1:0] aluY,
  output logic [DATA_W-1:0] resultX,
  output logic [DATA_W-1:0] resultY,
  output logic              out_valid
);

  localparam logic [DATA_W-1:0] PC_INC_VAL = DATA_W'(PC_INC);

  logic [DATA_W-1:0] simm;
  logic [DATA_W-1:0] zimm;
  logic [DATA_W-1:0] shamt;
  logic [DATA_W-1:0] lui;
  logic [DATA_W-1:0] boff;
  logic [DATA_W-1:0] nextX;
  logic [DATA_W-1:0] nextY;

  imm_extend #(.DATA_W(DATA_W)) uImmExtend (
    .instruction(instruction),
    .simm       (simm),
    .zimm       (zimm),
    .shamt      (shamt),
    .lui        (lui),
    .boff       (boff)
  );

  // X operand mux
  always_comb begin
    nextX = {DATA_W{1'b0}};
    case (aluX)
      ALUX_RS:   nextX = regSValue;
      ALUX_RT:   nextX = regTValue;
      ALUX_PC:   nextX = pc;
      ALUX_ZERO: nextX = {DATA_W{1'b0}};
      default:   nextX = {DATA_W{1'b0}};
    endcase
  end

  // Y operand mux
  always_comb begin
    nextY = {DATA_W{1'b0}};
    case (aluY)
      ALUY_RT:    nextY = regTValue;
      ALUY_SIMM:  nextY = simm;
      ALUY_ZIMM:  nextY = zimm;
      ALUY_SHAMT: nextY = shamt;
      ALUY_PC4:   nextY = PC_INC_VAL;
      ALUY_LUI:   nextY = lui;
      ALUY_BOFF:  nextY = boff;
      ALUY_ZERO:  nextY = {DATA_W{1'b0}};
      default:    nextY = {DATA_W{1'b0}};
    endcase
  end

  // Output register: operands load on every enabled edge, in_valid rides along
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resultX   <= {DATA_W{1'b0}};
      resultY   <= {DATA_W{1'b0}};
      out_valid <= 1'b0;
    end else if (en) begin
      resultX   <= nextX;
      resultY   <= nextY;
      out_valid <= in_valid;
    end else begin
      resultX   <= resultX;
      resultY   <= resultY;
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_alu_operand_select.sv
// Self-checking bench for alu_operand_select: directed vector table, timing sequences, random vs. model.
module tb_alu_operand_select;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        in_valid;
  logic [31:0] pc;
  logic [31:0] regTValue;
  logic [31:0] regSValue;
  logic [31:0] instruction;
  logic [1:0]  aluX;
  logic [2:0]  aluY;
  logic [31:0] resultX;
  logic [31:0] resultY;
  logic        out_valid;

  int passCnt;
  int totalCnt;

  alu_operand_select #(.DATA_W(32), .PC_INC(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .in_valid   (in_valid),
    .pc         (pc),
    .regTValue  (regTValue),
    .regSValue  (regSValue),
    .instruction(instruction),
    .aluX       (aluX),
    .aluY       (aluY),
    .resultX    (resultX),
    .resultY    (resultY),
    .out_valid  (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  selX;
    logic [2:0]  selY;
    logic [31:0] instr;
    logic [31:0] expX;
    logic [31:0] expY;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference: operand values from the ISA field definitions using plain arithmetic
  function automatic logic [31:0] refX(input logic [1:0] s, input logic [31:0] rs,
                                       input logic [31:0] rt, input logic [31:0] p);
    if (s == 2'd0) return rs;
    if (s == 2'd1) return rt;
    if (s == 2'd2) return p;
    return 32'd0;
  endfunction

  function automatic logic [31:0] refY(input logic [2:0] s, input logic [31:0] rt,
                                       input logic [31:0] ins);
    int unsigned imm;
    int          simmInt;
    imm     = ins % 65536;
    simmInt = (imm >= 32768) ? int'(imm) - 65536 : int'(imm);
    case (s)
      3'd0:    return rt;
      3'd1:    return 32'(simmInt);
      3'd2:    return 32'(imm);
      3'd3:    return 32'((ins / 64) % 32);
      3'd4:    return 32'd4;
      3'd5:    return 32'(imm * 65536);
      3'd6:    return 32'(simmInt * 4);
      default: return 32'd0;
    endcase
  endfunction

  task automatic setStd();
    pc          = 32'd104;
    regTValue   = 32'h0000_1234;
    regSValue   = 32'h0000_5678;
    instruction = 32'h0000_ABCD;
    en          = 1'b1;
    in_valid    = 1'b1;
  endtask

  task automatic edgeSample();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] holdX;
  logic [31:0] holdY;
  logic        holdV;
  logic [31:0] mX;
  logic [31:0] mY;
  logic        mV;

  initial begin
    passCnt  = 0;
    totalCnt = 0;

    vecs[0]  = '{2'd0, 3'd0, 32'h0000ABCD, 32'h00005678, 32'h00001234};
    vecs[1]  = '{2'd1, 3'd0, 32'h0000ABCD, 32'h00001234, 32'h00001234};
    vecs[2]  = '{2'd2, 3'd0, 32'h0000ABCD, 32'h00000068, 32'h00001234};
    vecs[3]  = '{2'd3, 3'd0, 32'h0000ABCD, 32'h00000000, 32'h00001234};
    vecs[4]  = '{2'd3, 3'd1, 32'h0000ABCD, 32'h00000000, 32'hFFFFABCD};
    vecs[5]  = '{2'd3, 3'd2, 32'h0000ABCD, 32'h00000000, 32'h0000ABCD};
    vecs[6]  = '{2'd3, 3'd3, 32'h0000ABCD, 32'h00000000, 32'h0000000F};
    vecs[7]  = '{2'd3, 3'd4, 32'h0000ABCD, 32'h00000000, 32'h00000004};
    vecs[8]  = '{2'd3, 3'd5, 32'h0000ABCD, 32'h00000000, 32'hABCD0000};
    vecs[9]  = '{2'd3, 3'd6, 32'h0000ABCD, 32'h00000000, 32'hFFFEAF34};
    vecs[10] = '{2'd3, 3'd7, 32'h0000ABCD, 32'h00000000, 32'h00000000};
    vecs[11] = '{2'd3, 3'd1, 32'h00001234, 32'h00000000, 32'h00001234};
    vecs[12] = '{2'd3, 3'd6, 32'h00001234, 32'h00000000, 32'h000048D0};
    vecs[13] = '{2'd3, 3'd3, 32'h00001234, 32'h00000000, 32'h00000008};
    vecs[14] = '{2'd1, 3'd5, 32'hFFFF8001, 32'h00001234, 32'h80010000};

    // Power-on reset
    rst_n = 1'b0;
    setStd();
    aluX = 2'd1;
    aluY = 3'd0;
    #2;
    check("por_x", resultX, 32'd0);
    check("por_y", resultY, 32'd0);
    check("por_v", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("por_hold_x", resultX, 32'd0);
    #3 rst_n = 1'b1;
    #1;
    check("rel_x_before_edge", resultX, 32'd0);
    check("rel_v_before_edge", {31'd0, out_valid}, 32'd0);
    edgeSample();
    check("rel_first_x", resultX, 32'h1234);
    check("rel_first_v", {31'd0, out_valid}, 32'd1);

    // Directed selection table
    for (int i = 0; i < 15; i++) begin
      aluX        = vecs[i].selX;
      aluY        = vecs[i].selY;
      instruction = vecs[i].instr;
      edgeSample();
      check($sformatf("vec%0d_x", i), resultX, vecs[i].expX);
      check($sformatf("vec%0d_y", i), resultY, vecs[i].expY);
    end

    // Latency: change just after an edge, result only moves at the next edge
    setStd();
    aluX = 2'd1;
    aluY = 3'd0;
    edgeSample();
    check("lat_x0", resultX, 32'h1234);
    aluX     = 2'd2;
    in_valid = 1'b0;
    #3;
    check("lat_x_mid", resultX, 32'h1234);
    check("lat_v_mid", {31'd0, out_valid}, 32'd1);
    edgeSample();
    check("lat_x1", resultX, 32'h68);
    check("lat_v1", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1;
    edgeSample();
    check("lat_v2", {31'd0, out_valid}, 32'd1);

    // Hold with en=0 while everything else changes
    holdX = resultX;
    holdY = resultY;
    holdV = out_valid;
    en          = 1'b0;
    aluX        = 2'd0;
    aluY        = 3'd5;
    regSValue   = 32'hDEAD_BEEF;
    regTValue   = 32'hCAFE_F00D;
    pc          = 32'h0000_1000;
    instruction = 32'h0000_7777;
    in_valid    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      edgeSample();
      check($sformatf("hold%0d_x", k), resultX, holdX);
      check($sformatf("hold%0d_y", k), resultY, holdY);
      check($sformatf("hold%0d_v", k), {31'd0, out_valid}, {31'd0, holdV});
    end
    en = 1'b1;
    edgeSample();
    check("hold_release_x", resultX, 32'hDEAD_BEEF);
    check("hold_release_y", resultY, 32'h7777_0000);
    check("hold_release_v", {31'd0, out_valid}, 32'd0);

    // Randomized stimulus against the reference model
    mX = resultX;
    mY = resultY;
    mV = out_valid;
    for (int r = 0; r < 200; r++) begin
      en          = ($urandom_range(0, 3) != 0);
      in_valid    = 1'($urandom);
      aluX        = 2'($urandom);
      aluY        = 3'($urandom);
      pc          = $urandom;
      regTValue   = $urandom;
      regSValue   = $urandom;
      instruction = $urandom;
      if (en) begin
        mX = refX(aluX, regSValue, regTValue, pc);
        mY = refY(aluY, regTValue, instruction);
        mV = in_valid;
      end
      edgeSample();
      check($sformatf("rnd%0d_x", r), resultX, mX);
      check($sformatf("rnd%0d_y", r), resultY, mY);
      check($sformatf("rnd%0d_v", r), {31'd0, out_valid}, {31'd0, mV});
    end

    // Mid-cycle asynchronous reset after outputs are non-zero
    setStd();
    aluX = 2'd0;
    aluY = 3'd4;
    edgeSample();
    check("pre_rst_x", resultX, 32'h5678);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_x", resultX, 32'd0);
    check("async_rst_y", resultY, 32'd0);
    check("async_rst_v", {31'd0, out_valid}, 32'd0);
    edgeSample();
    check("rst_held_y", resultY, 32'd0);
    #2 rst_n = 1'b1;
    en = 1'b0;
    edgeSample();
    check("rel_no_en_x", resultX, 32'd0);
    check("rel_no_en_v", {31'd0, out_valid}, 32'd0);
    en = 1'b1;
    edgeSample();
    check("rel_en_x", resultX, 32'h5678);
    check("rel_en_y", resultY, 32'h4);
    check("rel_en_v", {31'd0, out_valid}, 32'd1);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
